// File: rtl/capture_csr_bank.sv
// -----------------------------------------------------------------------------
// capture_csr_bank
//   Avalon-MM slave register bank between the H2F bridge and the packet-capture
//   datapath. It holds the control/status registers, a W1C interrupt block with
//   per-bit enables, a saturating packet counter with begin/end pointer
//   snapshots, and a first-word-fall-through descriptor FIFO that carries
//   SDRAM write addresses from the driver to the capture engine.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   address/read/write         Avalon-MM word address and strobes
//   writedata                  Avalon-MM write data
//   readdata/readdatavalid     registered read response (1-cycle latency)
//   state/busy/done            capture engine status inputs
//   pkt_begin_in/pkt_end_in    current packet pointers, latched on done edge
//   out_enable                 CONTROL[0]
//   desc_valid/desc_addr       FIFO head, popped on desc_valid && desc_ready
//   desc_ready                 engine accepts the head descriptor
//   irq                        registered |(IRQ_STATUS & IRQ_ENABLE)
// -----------------------------------------------------------------------------
module capture_csr_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  input  logic [1:0]        state,
  input  logic              busy,
  input  logic              done,
  input  logic [DATA_W-1:0] pkt_begin_in,
  input  logic [DATA_W-1:0] pkt_end_in,
  output logic              out_enable,
  output logic              desc_valid,
  output logic [DATA_W-1:0] desc_addr,
  input  logic              desc_ready,
  output logic              irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;   // extra bit distinguishes full from empty

  typedef enum logic [2:0] {
    A_CONTROL    = 3'd0,
    A_STATUS     = 3'd1,
    A_IRQ_STATUS = 3'd2,
    A_IRQ_ENABLE = 3'd3,
    A_DESC_PUSH  = 3'd4,
    A_PKT_COUNT  = 3'd5,
    A_LAST_BEGIN = 3'd6,
    A_LAST_END   = 3'd7
  } reg_addr_e;

  logic              enable_q;
  logic [2:0]        irq_status_q;
  logic [2:0]        irq_enable_q;
  logic              done_q;
  logic [CNT_W-1:0]  pkt_count_q;
  logic [DATA_W-1:0] last_begin_q;
  logic [DATA_W-1:0] last_end_q;
  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;

  logic [PW-1:0]     level;
  logic              fifo_full;
  logic              fifo_empty;
  logic              soft_clear;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              done_evt;
  logic [2:0]        irq_set;
  logic [2:0]        irq_clr;
  logic [2:0]        irq_status_d;
  logic [DATA_W-1:0] rd_mux;

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping and event detection
  // ---------------------------------------------------------------------------
  assign level      = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (level == PW'(DEPTH));
  assign fifo_empty = (level == '0);

  // soft_clear acts in the cycle CONTROL[1] is written and never stores a bit,
  // so it always reads back as 0.
  assign soft_clear = write && (address == A_CONTROL) && writedata[1];
  assign push_req   = write && (address == A_DESC_PUSH);

  assign desc_valid = !fifo_empty;
  assign desc_addr  = fifo_mem[rd_ptr_q[AW-1:0]];

  assign pop  = desc_valid && desc_ready && !soft_clear;
  // A push into a full FIFO is still accepted when a pop frees a slot.
  assign push = push_req && (!fifo_full || pop) && !soft_clear;

  assign done_evt = done && !done_q;

  assign irq_set[0] = done_evt;
  assign irq_set[1] = push_req && fifo_full && !pop;
  assign irq_set[2] = pop && !push && (level == PW'(1));

  assign irq_clr = (write && (address == A_IRQ_STATUS)) ? writedata[2:0] : 3'b000;
  // Hardware set is ORed in after the clear so a same-cycle set wins.
  assign irq_status_d = (irq_status_q & ~irq_clr) | irq_set;

  // ---------------------------------------------------------------------------
  // Read mux (current register values, so a same-cycle write is not visible)
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    rd_mux = '0;
    unique case (address)
      A_CONTROL:    rd_mux[0] = enable_q;
      A_STATUS: begin
        rd_mux[1:0]    = state;
        rd_mux[2]      = done;
        rd_mux[3]      = busy;
        rd_mux[4]      = fifo_full;
        rd_mux[5]      = fifo_empty;
        rd_mux[8 +: PW] = level;
      end
      A_IRQ_STATUS: rd_mux[2:0]       = irq_status_q;
      A_IRQ_ENABLE: rd_mux[2:0]       = irq_enable_q;
      A_DESC_PUSH:  rd_mux[PW-1:0]    = level;
      A_PKT_COUNT:  rd_mux[CNT_W-1:0] = pkt_count_q;
      A_LAST_BEGIN: rd_mux            = last_begin_q;
      A_LAST_END:   rd_mux            = last_end_q;
      default:      rd_mux            = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q      <= 1'b0;
      irq_status_q  <= '0;
      irq_enable_q  <= '0;
      done_q        <= 1'b0;
      pkt_count_q   <= '0;
      last_begin_q  <= '0;
      last_end_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
      irq           <= 1'b0;
    end else begin
      done_q        <= done;
      irq_status_q  <= irq_status_d;
      irq           <= |(irq_status_q & irq_enable_q);
      readdatavalid <= read;

      if (read) readdata <= rd_mux;

      if (write && (address == A_CONTROL))    enable_q     <= writedata[0];
      if (write && (address == A_IRQ_ENABLE)) irq_enable_q <= writedata[2:0];

      if (soft_clear) begin
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        pkt_count_q  <= '0;
        last_begin_q <= '0;
        last_end_q   <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        if (done_evt) begin
          if (pkt_count_q != '1) pkt_count_q <= pkt_count_q + CNT_W'(1);
          last_begin_q <= pkt_begin_in;
          last_end_q   <= pkt_end_in;
        end
      end
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; the pointers define which
  // entries are valid, and leaving the array out of reset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= writedata;
  end

  assign out_enable = enable_q;

endmodule

// File: tb/tb_capture_csr_bank.sv
module tb_capture_csr_bank;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic [1:0]        state;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] pkt_begin_in;
  logic [DATA_W-1:0] pkt_end_in;
  logic              out_enable;
  logic              desc_valid;
  logic [DATA_W-1:0] desc_addr;
  logic              desc_ready;
  logic              irq;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic        read_prev;

  always #5 clk = ~clk;

  capture_csr_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .state         (state),
    .busy          (busy),
    .done          (done),
    .pkt_begin_in  (pkt_begin_in),
    .pkt_end_in    (pkt_end_in),
    .out_enable    (out_enable),
    .desc_valid    (desc_valid),
    .desc_addr     (desc_addr),
    .desc_ready    (desc_ready),
    .irq           (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus transaction; a read queues its expected response for the monitor.
  task automatic bus(input bit do_rd, input bit do_wr, input logic [2:0] a,
                     input logic [31:0] wd, input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    read = do_rd; write = do_wr; address = a; writedata = wd;
    if (do_rd) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    bus(1'b0, 1'b1, a, wd, 32'h0, "");
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    bus(1'b1, 1'b0, a, 32'h0, exp, tag);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
  endtask

  task automatic pop_one(input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(desc_valid), 32'h1);
    check(tag, desc_addr, exp);
    desc_ready = 1'b1;
    @(posedge clk); #1 desc_ready = 1'b0;
  endtask

  // Reference for response timing: readdatavalid must follow read by one edge.
  always @(posedge clk or posedge reset) begin
    if (reset) read_prev <= 1'b0;
    else       read_prev <= read;
  end

  always @(negedge clk) begin
    if (!reset && (readdatavalid || read_prev)) begin
      check("rvalid_timing", 32'(readdatavalid), 32'(read_prev));
      if (readdatavalid) begin
        if (exp_q.size() == 0) check("spurious_rvalid", 32'(readdatavalid), 32'h0);
        else                   check(tag_q.pop_front(), readdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    state = '0; busy = 1'b0; done = 1'b0; desc_ready = 1'b0;
    pkt_begin_in = '0; pkt_end_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset arriving while a read response is pending drops it.
    @(posedge clk); #1 read = 1'b1; address = 3'd5;
    @(posedge clk); #1 read = 1'b0; reset = 1'b1;
    #1;
    check("rst_rvalid", 32'(readdatavalid), 32'h0);
    check("rst_rdata", readdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_desc_valid", 32'(desc_valid), 32'h0);
    check("rst_out_enable", 32'(out_enable), 32'h0);

    rd(3'd0, 32'h0,  "rst_control");
    rd(3'd1, 32'h20, "rst_status");
    rd(3'd2, 32'h0,  "rst_irq_status");
    rd(3'd3, 32'h0,  "rst_irq_enable");
    rd(3'd4, 32'h0,  "rst_desc_level");
    rd(3'd5, 32'h0,  "rst_pkt_count");
    rd(3'd6, 32'h0,  "rst_last_begin");
    rd(3'd7, 32'h0,  "rst_last_end");

    // Descriptor flow: fill, overflow, push+pop while full, drain.
    for (int i = 1; i <= 4; i++) wr(3'd4, 32'(i) << 12);
    rd(3'd1, 32'h410, "full_status");
    wr(3'd4, 32'h5000);
    rd(3'd2, 32'h2, "overflow_irq");
    rd(3'd4, 32'h4, "level_after_overflow");

    @(posedge clk); #1;
    check("head_before_pushpop", desc_addr, 32'h1000);
    write = 1'b1; address = 3'd4; writedata = 32'h6000; desc_ready = 1'b1;
    @(posedge clk); #1 write = 1'b0; desc_ready = 1'b0;
    rd(3'd4, 32'h4, "level_pushpop_full");

    pop_one(32'h2000, "pop0");
    pop_one(32'h3000, "pop1");
    pop_one(32'h4000, "pop2");
    pop_one(32'h6000, "pop3");
    check("drained_desc_valid", 32'(desc_valid), 32'h0);
    rd(3'd2, 32'h6, "empty_evt_irq");
    rd(3'd1, 32'h20, "drained_status");
    wr(3'd2, 32'h6);
    rd(3'd2, 32'h0, "w1c_clear");

    // Done event: counter, snapshots, irq latency and clear.
    wr(3'd3, 32'h1);
    pkt_begin_in = 32'hA0; pkt_end_in = 32'h1F0;
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    check("irq_lag", 32'(irq), 32'h0);
    @(posedge clk); #1;
    check("irq_set", 32'(irq), 32'h1);
    rd(3'd5, 32'h1,   "pkt_count_1");
    rd(3'd6, 32'hA0,  "last_begin");
    rd(3'd7, 32'h1F0, "last_end");
    rd(3'd2, 32'h1,   "done_evt_irq");
    wr(3'd2, 32'h1);
    @(posedge clk); #1;
    check("irq_cleared", 32'(irq), 32'h0);

    // W1C racing a done edge: the set wins.
    @(posedge clk); #1;
    done = 1'b1; write = 1'b1; address = 3'd2; writedata = 32'h1;
    @(posedge clk); #1 done = 1'b0; write = 1'b0;
    rd(3'd2, 32'h1, "w1c_vs_set");

    // Same-cycle read/write returns the old value; unused enable bits read 0.
    bus(1'b1, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'h1, "read_before_write");
    rd(3'd3, 32'h7, "irq_enable_mask");

    // Saturation: 20 done pulses in total on a 4-bit counter.
    repeat (18) pulse_done();
    rd(3'd5, 32'hF, "pkt_count_sat");

    // soft_clear.
    wr(3'd0, 32'h2);
    rd(3'd5, 32'h0, "sc0_pkt_count");
    wr(3'd0, 32'h1);
    check("out_enable_on", 32'(out_enable), 32'h1);
    pkt_begin_in = 32'hB0; pkt_end_in = 32'h2F0;
    repeat (3) pulse_done();
    wr(3'd4, 32'h7000);
    wr(3'd4, 32'h8000);
    rd(3'd1, 32'h200, "pre_sc_status");
    rd(3'd5, 32'h3,   "pre_sc_pkt_count");
    rd(3'd6, 32'hB0,  "pre_sc_last_begin");
    wr(3'd0, 32'h3);
    rd(3'd0, 32'h1,  "sc_control");
    rd(3'd4, 32'h0,  "sc_level");
    rd(3'd1, 32'h20, "sc_status");
    rd(3'd5, 32'h0,  "sc_pkt_count");
    rd(3'd6, 32'h0,  "sc_last_begin");
    rd(3'd7, 32'h0,  "sc_last_end");
    rd(3'd2, 32'h1,  "sc_irq_status");
    rd(3'd3, 32'h7,  "sc_irq_enable");
    check("sc_desc_valid", 32'(desc_valid), 32'h0);
    check("sc_out_enable", 32'(out_enable), 32'h1);
    check("sc_irq", 32'(irq), 32'h1);

    // Live status inputs.
    state = 2'b11; busy = 1'b1;
    rd(3'd1, 32'h2B, "status_inputs");
    state = 2'b00; busy = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
